// File: rtl/rom_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_sequencer_if
// Purpose  : Bundles the start control, the ROM address/data pair and the
//            status outputs of rom_sequencer. The master side is the
//            sequencer. The slave side is the ROM plus its controller.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_sequencer_if #(
    parameter int ACC_W = 4
);
    logic             start;
    logic             a1;
    logic             a0;
    logic             o1;
    logic             o0;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [7:0]       icount;
    logic             busy;
    logic             halted;
    logic             err;

    modport master (
        input  start, o1, o0,
        output a1, a0, acc, ovf, icount, busy, halted, err
    );

    modport slave (
        output start, o1, o0,
        input  a1, a0, acc, ovf, icount, busy, halted, err
    );
endinterface
`default_nettype wire

// File: rtl/rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_sequencer
// Purpose  : Fetch/execute controller for a 4-word, 2-bit instruction ROM.
//            It executes INC (00), JNO (01) and HLT (10). Opcode 11 halts the
//            sequencer and sets a sticky error flag. ACC_W must be >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module rom_sequencer #(
    parameter int ACC_W = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rom_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OPER  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] c_OP_INC     = 2'b00;
    localparam logic [1:0] c_OP_JNO     = 2'b01;
    localparam logic [1:0] c_OP_HLT     = 2'b10;
    localparam logic [7:0] c_ICOUNT_MAX = 8'hFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_pc;
    logic [1:0]       w_pc_nxt;
    logic [1:0]       r_ir;
    logic [1:0]       w_ir_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [7:0]       r_icount;
    logic [7:0]       w_icount_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_retire;
    logic [1:0]       w_addr;
    logic [1:0]       w_rom_word;
    logic [ACC_W:0]   w_inc_sum;

    assign w_rom_word = {bus.o1, bus.o0};

    // The increment is one bit wider than acc so that its carry-out becomes ovf.
    assign w_inc_sum  = {1'b0, r_acc} + {{ACC_W{1'b0}}, 1'b1};

    // Address mux: OPER reads the operand word that follows the JNO opcode.
    always_comb begin
        w_addr = r_pc;
        if (r_state == S_OPER) begin
            w_addr = r_pc + 2'd1;
        end
    end

    // Next-state logic and register updates for every state of the fetch/execute loop.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_acc_nxt    = r_acc;
        w_ovf_nxt    = r_ovf;
        w_err_nxt    = r_err;
        w_icount_nxt = r_icount;
        w_retire     = 1'b0;

        unique case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    w_pc_nxt     = 2'd0;
                    w_acc_nxt    = '0;
                    w_ovf_nxt    = 1'b0;
                    w_icount_nxt = 8'd0;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_FETCH: begin
                w_ir_nxt    = w_rom_word;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                unique case (r_ir)
                    c_OP_INC: begin
                        {w_ovf_nxt, w_acc_nxt} = w_inc_sum;
                        w_pc_nxt    = r_pc + 2'd1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    c_OP_JNO: begin
                        if (r_ovf) begin
                            // The jump is not taken, so the operand word is skipped.
                            w_pc_nxt    = r_pc + 2'd2;
                            w_retire    = 1'b1;
                            w_state_nxt = S_FETCH;
                        end else begin
                            // The jump is taken. The instruction retires in OPER.
                            w_state_nxt = S_OPER;
                        end
                    end
                    c_OP_HLT: begin
                        w_retire    = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                    default: begin
                        w_err_nxt   = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                endcase
            end
            S_OPER: begin
                w_pc_nxt    = w_rom_word;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_retire && (r_icount != c_ICOUNT_MAX)) begin
            w_icount_nxt = r_icount + 8'd1;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: pc, ir, accumulator, flags and retired-instruction count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= 2'd0;
            r_ir     <= 2'b00;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_icount <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_acc    <= w_acc_nxt;
            r_ovf    <= w_ovf_nxt;
            r_icount <= w_icount_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.a1     = w_addr[1];
    assign bus.a0     = w_addr[0];
    assign bus.acc    = r_acc;
    assign bus.ovf    = r_ovf;
    assign bus.icount = r_icount;
    assign bus.err    = r_err;
    assign bus.busy   = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_OPER);
    assign bus.halted = (r_state == S_HALT);

endmodule
`default_nettype wire
